// File: rtl/traceback_v3_pkg.sv
// Shared traceback types and width helpers, also used by the survivor RAM and ACS blocks.
package traceback_pkg;

   typedef enum logic [1:0] {
      TB_IDLE,
      TB_RUN,
      TB_DRAIN
   } tb_fsm_e;

   function automatic int tb_time_w(input int d);
      return (d > 1) ? $clog2(d) : 1;
   endfunction

   function automatic int tb_step_w(input int l, input int b);
      return $clog2(l + b + 1);
   endfunction

   function automatic int tb_idx_w(input int b);
      return (b > 1) ? $clog2(b) : 1;
   endfunction

endpackage

// File: rtl/traceback_v3_rev_buf.sv
// B x 1 reversal store: single indexed write port, combinational indexed read, contents unreset.
// Write lands on the clock edge; read reflects it from the following cycle.
module tb_rev_buf #(
   parameter int B  = 8,
   parameter int IW = 3
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [IW-1:0] waddr_i,
   input  logic          wdat_i,
   input  logic [IW-1:0] raddr_i,
   output logic          rdat_o
);

   logic [B-1:0] mem_q;

   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdat_i;
   end

   assign rdat_o = mem_q[raddr_i];

endmodule

// File: rtl/traceback_v3.sv
// Block Viterbi traceback: L+B steps back per start, emits last B bits oldest-first; first bit 1+L+B cycles after start.
// Output holds while dec_ready=0; new starts accepted only in IDLE. TRACEBACK_V3_STATS_EN enables the block counter.
module traceback_v3
   import traceback_pkg::*;
#(
   parameter int K = 7,
   parameter int D = 64,
   parameter int L = 32,
   parameter int B = 8,
   localparam int M  = K - 1,
   localparam int TW = tb_time_w(D)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   output logic          start_ready,
   input  logic [TW-1:0] start_time,
   input  logic [M-1:0]  start_state,
   input  logic          force_state0,
   output logic [TW-1:0] tb_time,
   output logic [M-1:0]  tb_state,
   input  logic          tb_surv_bit,
   output logic          busy,
   output logic          dec_valid,
   input  logic          dec_ready,
   output logic          dec_bit,
   output logic          dec_last,
   output logic [31:0]   stat_tb_count
);

   localparam int SW = tb_step_w(L, B);
   localparam int IW = tb_idx_w(B);
   localparam logic [SW-1:0] L_STEP    = SW'(L);
   localparam logic [SW-1:0] LAST_STEP = SW'(L + B - 1);
   localparam logic [TW-1:0] TIME_MAX  = TW'(D - 1);
   localparam logic [IW-1:0] IDX_MAX   = IW'(B - 1);

   tb_fsm_e       state_q;
   logic [TW-1:0] tb_time_q, tb_time_d;
   logic [M-1:0]  tb_state_q, tb_state_d;
   logic [M:0]    state_shift;
   logic [SW-1:0] step_q;
   logic [IW-1:0] rd_idx_q, wr_idx, rd_addr;
   logic          dec_valid_q, dec_bit_q, dec_last_q;
   logic          buf_we, buf_rdat, xfer;

   // The survivor bit becomes the new MSB of the predecessor state.
   assign state_shift = {tb_surv_bit, tb_state_q};
   assign tb_state_d  = state_shift[M:1];
   assign tb_time_d   = (tb_time_q == '0) ? TIME_MAX : tb_time_q - TW'(1);

   assign buf_we  = (state_q == TB_RUN) && (step_q >= L_STEP);
   assign wr_idx  = IW'(step_q - L_STEP);
   assign rd_addr = rd_idx_q - IW'(1);
   assign xfer    = dec_valid_q & dec_ready;

   tb_rev_buf #(.B(B), .IW(IW)) u_rev_buf (
      .clk_i   (clk),
      .we_i    (buf_we),
      .waddr_i (wr_idx),
      .wdat_i  (tb_surv_bit),
      .raddr_i (rd_addr),
      .rdat_o  (buf_rdat)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= TB_IDLE;
         tb_time_q   <= '0;
         tb_state_q  <= '0;
         step_q      <= '0;
         rd_idx_q    <= '0;
         dec_valid_q <= 1'b0;
         dec_bit_q   <= 1'b0;
         dec_last_q  <= 1'b0;
      end else begin
         case (state_q)
            TB_IDLE: begin
               if (start) begin
                  tb_time_q  <= start_time;
                  tb_state_q <= force_state0 ? '0 : start_state;
                  step_q     <= '0;
                  state_q    <= TB_RUN;
               end
            end
            TB_RUN: begin
               tb_state_q <= tb_state_d;
               tb_time_q  <= tb_time_d;
               step_q     <= step_q + SW'(1);
               if (step_q == LAST_STEP) begin
                  // The final step's bit is the oldest one, so it is presented straight away.
                  state_q     <= TB_DRAIN;
                  rd_idx_q    <= IDX_MAX;
                  dec_valid_q <= 1'b1;
                  dec_bit_q   <= tb_surv_bit;
                  dec_last_q  <= (B == 1);
               end
            end
            TB_DRAIN: begin
               if (xfer) begin
                  if (dec_last_q) begin
                     state_q     <= TB_IDLE;
                     dec_valid_q <= 1'b0;
                     dec_bit_q   <= 1'b0;
                     dec_last_q  <= 1'b0;
                  end else begin
                     rd_idx_q   <= rd_addr;
                     dec_bit_q  <= buf_rdat;
                     dec_last_q <= (rd_idx_q == IW'(1));
                  end
               end
            end
            default: state_q <= TB_IDLE;
         endcase
      end
   end

   assign start_ready = (state_q == TB_IDLE);
   assign busy        = (state_q != TB_IDLE);
   assign tb_time     = tb_time_q;
   assign tb_state    = tb_state_q;
   assign dec_valid   = dec_valid_q;
   assign dec_bit     = dec_bit_q;
   assign dec_last    = dec_last_q;

`ifdef TRACEBACK_V3_STATS_EN
   logic [31:0] stat_q;

   always_ff @(posedge clk) begin
      if (rst)                                      stat_q <= '0;
      else if (xfer && dec_last_q && stat_q != '1)  stat_q <= stat_q + 32'd1;
   end

   assign stat_tb_count = stat_q;
`else
   assign stat_tb_count = '0;
`endif

endmodule

// File: tb/tb_traceback_v3.sv
// Randomized bench for traceback_v3: a survivor-RAM array feeds the DUT, a reference walk fills scoreboard queues.
module tb_traceback_v3;

   localparam int K  = 7;
   localparam int M  = K - 1;
   localparam int D  = 64;
   localparam int L  = 32;
   localparam int B  = 8;
   localparam int TW = 6;
   localparam int NS = L + B;
   localparam int NST = 1 << M;
`ifdef TRACEBACK_V3_STATS_EN
   localparam bit STAT_ON = 1'b1;
`else
   localparam bit STAT_ON = 1'b0;
`endif

   typedef struct packed { logic b; logic last; } exp_t;
   typedef struct packed { logic [TW-1:0] t; logic [M-1:0] s; } tr_t;

   logic          clk, rst, start, start_ready, force_state0, tb_surv_bit;
   logic          busy, dec_valid, dec_ready, dec_bit, dec_last;
   logic [TW-1:0] start_time, tb_time;
   logic [M-1:0]  start_state, tb_state;
   logic [31:0]   stat_tb_count;

   traceback_v3 #(.K(K), .D(D), .L(L), .B(B)) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .start_ready   (start_ready),
      .start_time    (start_time),
      .start_state   (start_state),
      .force_state0  (force_state0),
      .tb_time       (tb_time),
      .tb_state      (tb_state),
      .tb_surv_bit   (tb_surv_bit),
      .busy          (busy),
      .dec_valid     (dec_valid),
      .dec_ready     (dec_ready),
      .dec_bit       (dec_bit),
      .dec_last      (dec_last),
      .stat_tb_count (stat_tb_count)
   );

   logic ram [0:D-1][0:NST-1];
   assign tb_surv_bit = ram[tb_time][tb_state];

   int   total = 0, bad = 0, cyc = 0, xfers = 0, exp_stat = 0, lat_exp = 0, rdy_mode = 0;
   bit   lat_pending = 0, held_vld = 0;
   logic held_bit, held_last;
   exp_t exp_q[$];
   tr_t  tr_q[$];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic fail(input string name, input logic [31:0] act, input logic [31:0] req);
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) fail(name, act, req);
   endtask

   // Reference walk: follow survivor bits back L+B slots, keep the last B, emit oldest first.
   task automatic model(input int t0, input int s0);
      int   t, st;
      logic bits[NS];
      tr_t  tr;
      exp_t e;
      t  = t0;
      st = s0;
      for (int i = 0; i < NS; i++) begin
         tr.t = TW'(t);
         tr.s = M'(st);
         tr_q.push_back(tr);
         bits[i] = ram[t][st];
         st = (bits[i] ? NST / 2 : 0) + st / 2;
         t  = (t == 0) ? D - 1 : t - 1;
      end
      for (int i = NS - 1; i >= L; i--) begin
         e.b    = bits[i];
         e.last = (i == L);
         exp_q.push_back(e);
      end
   endtask

   // Monitor: trellis-walk addresses during RUN, output bits and stall stability during DRAIN.
   always @(negedge clk) begin
      if (rst) begin
         held_vld = 0;
      end else begin
         if (lat_pending && (dec_valid || cyc >= lat_exp)) begin
            chk("first_valid_latency", dec_valid ? cyc : -1, lat_exp);
            lat_pending = 0;
         end
         if (busy && !dec_valid) begin
            if (tr_q.size() == 0) begin
               total++;
               fail("extra_trellis_step", tb_time, 0);
            end else begin
               tr_t tr;
               tr = tr_q.pop_front();
               chk("tb_time", tb_time, tr.t);
               chk("tb_state", tb_state, tr.s);
            end
         end
         if (held_vld) chk("stall_hold", {dec_valid, dec_bit, dec_last}, {1'b1, held_bit, held_last});
         held_vld = 0;
         if (dec_valid) begin
            if (dec_ready) begin
               xfers++;
               if (exp_q.size() == 0) begin
                  total++;
                  fail("unexpected_bit", dec_bit, 0);
               end else begin
                  exp_t e;
                  e = exp_q.pop_front();
                  chk("dec_bit", dec_bit, e.b);
                  chk("dec_last", dec_last, e.last);
                  if (e.last) exp_stat++;
               end
            end else begin
               held_vld  = 1;
               held_bit  = dec_bit;
               held_last = dec_last;
            end
         end
      end
   end

   // Sink: always ready, the 1,0,0,1 pattern, or random.
   initial begin
      int ph;
      logic [3:0] pat;
      ph = 0;
      pat = 4'b1001;
      dec_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       dec_ready = 1'b1;
            1:       dec_ready = pat[ph % 4];
            default: dec_ready = 1'($urandom_range(0, 1));
         endcase
         ph++;
      end
   end

   task automatic issue(input int t, input int s, input bit f0, input bit pulse);
      int n;
      n = 0;
      @(negedge clk);
      while (!start_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!start_ready) begin
         total++;
         fail("start_ready_timeout", start_ready, 1);
         return;
      end
      start_time   = TW'(t);
      start_state  = M'(s);
      force_state0 = f0;
      start        = 1'b1;
      model(t, f0 ? 0 : s);
      lat_exp     = cyc + 1 + L + B;
      lat_pending = 1;
      @(posedge clk);
      #1;
      start        = 1'b0;
      start_time   = TW'($urandom);
      start_state  = M'($urandom);
      force_state0 = 1'($urandom);
      if (pulse) begin
         repeat (5) @(posedge clk);
         #1 start = 1'b1;
         repeat (4) @(posedge clk);
         #1 start = 1'b0;
      end
   endtask

   task automatic wait_idle();
      for (int n = 0; n < 600; n++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && tr_q.size() == 0 && !busy && !dec_valid) return;
      end
      total++;
      fail("drain_timeout", exp_q.size(), 0);
   endtask

   // Called just after a posedge; holds rst for one edge, then checks the idle state.
   task automatic apply_rst();
      #1 rst = 1'b1;
      exp_q.delete();
      tr_q.delete();
      lat_pending = 0;
      exp_stat    = 0;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_start_ready", start_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_dec_valid", dec_valid, 0);
      chk("rst_tb_time", tb_time, 0);
   endtask

   task automatic fill_ram(input int mode);
      for (int t = 0; t < D; t++)
         for (int s = 0; s < NST; s++)
            ram[t][s] = (mode == 0) ? 1'b0 :
                        (mode == 1) ? ((t >= 56) ? 1'b1 : 1'b0) : 1'($urandom_range(0, 1));
   endtask

   initial begin
      int base, n;
      rst = 1'b1;
      start = 1'b0;
      start_time = '0;
      start_state = '0;
      force_state0 = 1'b0;
      fill_ram(0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_start_ready", start_ready, 1);
      chk("reset_busy", busy, 0);
      chk("reset_dec_valid", dec_valid, 0);
      chk("reset_dec_bit", dec_bit, 0);
      chk("reset_dec_last", dec_last, 0);
      chk("reset_tb_time", tb_time, 0);
      chk("reset_tb_state", tb_state, 0);
      chk("reset_stat", stat_tb_count, 0);
      @(posedge clk);
      #1 rst = 1'b0;

      rdy_mode = 0;
      issue(10, 0, 0, 0);
      wait_idle();

      fill_ram(1);
      issue(23, $urandom_range(0, NST - 1), 0, 0);
      wait_idle();

      fill_ram(2);
      rdy_mode = 1;
      issue($urandom_range(0, D - 1), $urandom_range(0, NST - 1), 0, 0);
      wait_idle();

      rdy_mode = 2;
      issue($urandom_range(0, D - 1), 'h2A, 1, 1);
      wait_idle();

      rdy_mode = 0;
      issue($urandom_range(0, D - 1), $urandom_range(0, NST - 1), 0, 0);
      repeat (20) @(posedge clk);
      apply_rst();
      issue($urandom_range(0, D - 1), $urandom_range(0, NST - 1), 0, 0);
      wait_idle();

      issue($urandom_range(0, D - 1), $urandom_range(0, NST - 1), 0, 0);
      base = xfers;
      n = 0;
      while (xfers < base + 3 && n < 300) begin
         @(posedge clk);
         n++;
      end
      if (xfers < base + 3) begin
         total++;
         fail("drain_start_timeout", xfers - base, 3);
      end
      apply_rst();
      issue($urandom_range(0, D - 1), $urandom_range(0, NST - 1), 0, 0);
      wait_idle();

      @(posedge clk);
      apply_rst();
      fill_ram(2);
      for (int i = 0; i < 5; i++)
         issue($urandom_range(0, D - 1), $urandom_range(0, NST - 1), 0, 0);
      wait_idle();
      chk("stat_after_5", stat_tb_count, STAT_ON ? 5 : 0);

      for (int i = 0; i < 6; i++) begin
         fill_ram(2);
         rdy_mode = $urandom_range(0, 2);
         issue($urandom_range(0, D - 1), $urandom_range(0, NST - 1), 1'($urandom_range(0, 1)), 0);
         wait_idle();
      end
      chk("stat_final", stat_tb_count, STAT_ON ? exp_stat : 0);
      chk("leftover_bits", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
      $fatal(1);
   end

endmodule
